// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral register bus: widths, arbiter state
// encoding, watchdog error data and the arbitration pick rule.
package bus_pkg;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_WD_W   = 8;

    localparam logic [31:0] BUS_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_H = 2'd1,
        GNT_C = 2'd2
    } arb_state_t;

    // Winner of a fresh arbitration; last = 1 means the core held the previous grant.
    function automatic arb_state_t arb_pick(
        input logic h_req,
        input logic c_req,
        input logic prio,
        input logic last
    );
        arb_state_t pick;
        pick = IDLE;
        if (h_req && c_req) begin
            if (prio || last) begin
                pick = GNT_H;
            end else begin
                pick = GNT_C;
            end
        end else if (h_req) begin
            pick = GNT_H;
        end else if (c_req) begin
            pick = GNT_C;
        end else begin
            pick = IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Register-bus port bundle (cs/we/addr/wdata out, ack/rdata back).
// master = side that issues transactions, slave = side that answers them.
interface bus_arbiter_if
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
);
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output cs, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  cs, we, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/bus_watchdog.sv
// Stall watchdog for bus_arbiter: counts granted cycles without a target ack.
// Only present when BUS_ARB_TIMEOUT_EN is defined.
`ifdef BUS_ARB_TIMEOUT_EN
module bus_watchdog
    import bus_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic Rst,
    input  logic active,
    input  logic done,
    output logic expired
);
    localparam logic [BUS_WD_W-1:0] LIMIT_C = BUS_WD_W'(LIMIT);

    logic [BUS_WD_W-1:0] cnt_r;

    // Held at zero outside a grant, so every grant starts counting from zero.
    always_ff @(posedge clk) begin
        if (Rst) begin
            cnt_r <= 8'd0;
        end else if (!active) begin
            cnt_r <= 8'd0;
        end else if (!done) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = active && (cnt_r == LIMIT_C);

endmodule
`endif

// File: rtl/bus_arbiter.sv
// Two-master (host / core) round-robin arbiter for the peripheral register bus.
// Defining BUS_ARB_TIMEOUT_EN adds a stall watchdog that aborts with err.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W         = BUS_ADDR_W,
    parameter int DATA_W         = BUS_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic          host_prio,
    bus_arbiter_if.slave  host,
    bus_arbiter_if.slave  core,
    bus_arbiter_if.master tgt,
    output logic          err
);
    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    logic              last_r;
    logic              last_nxt_s;
    logic              sel_cs_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              granted_s;
    logic              done_s;
    logic              wd_expired_s;
    logic              wd_fire_s;
    logic [DATA_W-1:0] resp_rdata_s;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must fit the 8-bit watchdog counter");
    end

    // Route the granted requester onto the target bus; all zero outside a grant.
    always_comb begin
        sel_cs_s    = 1'b0;
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        case (state_r)
            GNT_H: begin
                sel_cs_s    = host.cs;
                sel_we_s    = host.we;
                sel_addr_s  = host.addr;
                sel_wdata_s = host.wdata;
            end
            GNT_C: begin
                sel_cs_s    = core.cs;
                sel_we_s    = core.we;
                sel_addr_s  = core.addr;
                sel_wdata_s = core.wdata;
            end
            default: begin
                sel_cs_s    = 1'b0;
                sel_we_s    = 1'b0;
                sel_addr_s  = {ADDR_W{1'b0}};
                sel_wdata_s = {DATA_W{1'b0}};
            end
        endcase
    end

    assign tgt.cs    = sel_cs_s;
    assign tgt.we    = sel_we_s;
    assign tgt.addr  = sel_addr_s;
    assign tgt.wdata = sel_wdata_s;

    assign granted_s = (state_r == GNT_H) || (state_r == GNT_C);
    assign done_s    = granted_s & tgt.ack;

`ifdef BUS_ARB_TIMEOUT_EN
    bus_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .Rst     (Rst),
        .active  (granted_s),
        .done    (done_s),
        .expired (wd_expired_s)
    );
`else
    assign wd_expired_s = 1'b0;
`endif

    // A real ack in the expiry cycle wins; an already-aborted request never expires.
    assign wd_fire_s    = wd_expired_s & sel_cs_s & ~tgt.ack;
    assign resp_rdata_s = wd_fire_s ? DATA_W'(BUS_ERR_RDATA) : tgt.rdata;
    assign err          = wd_fire_s;

    // Response path back to the granted port only; the other port sees zeros.
    always_comb begin
        host.ack   = 1'b0;
        host.rdata = {DATA_W{1'b0}};
        core.ack   = 1'b0;
        core.rdata = {DATA_W{1'b0}};
        if (state_r == GNT_H) begin
            host.ack   = done_s | wd_fire_s;
            host.rdata = resp_rdata_s;
        end else if (state_r == GNT_C) begin
            core.ack   = done_s | wd_fire_s;
            core.rdata = resp_rdata_s;
        end else begin
            host.ack   = 1'b0;
            core.ack   = 1'b0;
        end
    end

    // Next grant and round-robin pointer.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        case (state_r)
            IDLE: begin
                state_nxt_s = arb_pick(host.cs, core.cs, host_prio, last_r);
            end
            GNT_H, GNT_C: begin
                if (tgt.ack || wd_fire_s) begin
                    state_nxt_s = IDLE;
                    last_nxt_s  = (state_r == GNT_C);
                end else if (!sel_cs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register; after reset the host wins the first tie.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized self-checking bench for bus_arbiter against a cycle-level reference
// model; watchdog scenarios are exercised when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 4;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic Rst;
    logic host_prio;
    logic err;

    bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) h_if ();
    bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) c_if ();
    bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

    bus_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .Rst       (Rst),
        .host_prio (host_prio),
        .host      (h_if),
        .core      (c_if),
        .tgt       (m_if),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the bus (0 none, 1 host, 2 core), who owned it last,
    // and how many granted cycles have passed without an ack.
    int owner;
    bit last_was_core;
    int stall;

    logic        obs_h_ack, obs_c_ack, obs_m_cs, obs_err;
    logic [31:0] obs_h_rdata, obs_c_rdata;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs set; checks, then advances one clock.
    task automatic cycle();
        logic        e_mcs, e_mwe, e_hack, e_cack, e_err, req, fire;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata, e_hrd, e_crd, resp;
        #1;
        e_mcs = 1'b0; e_mwe = 1'b0; e_addr = 8'h00; e_wdata = 32'h0;
        e_hack = 1'b0; e_cack = 1'b0; e_hrd = 32'h0; e_crd = 32'h0;
        req  = (owner == 1) ? h_if.cs : (owner == 2) ? c_if.cs : 1'b0;
        fire = WD_ON && (owner != 0) && (stall == TMO) && req && !m_if.ack;
        resp = fire ? 32'hDEAD_BEEF : m_if.rdata;
        if (owner == 1) begin
            e_mcs = h_if.cs; e_mwe = h_if.we; e_addr = h_if.addr; e_wdata = h_if.wdata;
            e_hack = m_if.ack | fire; e_hrd = resp;
        end
        if (owner == 2) begin
            e_mcs = c_if.cs; e_mwe = c_if.we; e_addr = c_if.addr; e_wdata = c_if.wdata;
            e_cack = m_if.ack | fire; e_crd = resp;
        end
        e_err = fire;
        check_eq("m_cs", m_if.cs, e_mcs);
        check_eq("m_we", m_if.we, e_mwe);
        check_eq("m_addr", m_if.addr, e_addr);
        check_eq("m_wdata", m_if.wdata, e_wdata);
        check_eq("h_ack", h_if.ack, e_hack);
        check_eq("h_rdata", h_if.rdata, e_hrd);
        check_eq("c_ack", c_if.ack, e_cack);
        check_eq("c_rdata", c_if.rdata, e_crd);
        check_eq("err", err, e_err);
        obs_h_ack = h_if.ack; obs_c_ack = c_if.ack; obs_m_cs = m_if.cs; obs_err = err;
        obs_h_rdata = h_if.rdata; obs_c_rdata = c_if.rdata;
        @(posedge clk);
        if (Rst) begin
            owner = 0; last_was_core = 1'b1; stall = 0;
        end else if (owner == 0) begin
            stall = 0;
            if (h_if.cs && c_if.cs) owner = (host_prio || last_was_core) ? 1 : 2;
            else if (h_if.cs)       owner = 1;
            else if (c_if.cs)       owner = 2;
        end else if (m_if.ack || fire) begin
            last_was_core = (owner == 2);
            owner = 0;
        end else if (!req) begin
            owner = 0;
        end else begin
            stall++;
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        h_if.cs = 1'b0; h_if.we = 1'b0; h_if.addr = 8'h00; h_if.wdata = 32'h0;
        c_if.cs = 1'b0; c_if.we = 1'b0; c_if.addr = 8'h00; c_if.wdata = 32'h0;
        m_if.ack = 1'b0; m_if.rdata = 32'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end of test, expected $finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int seq_h [4];
        int n;
        quiet();
        host_prio = 1'b0;
        Rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        owner = 0; last_was_core = 1'b1; stall = 0;
        check_eq("rst_m_cs", m_if.cs, 1'b0);
        check_eq("rst_m_addr", m_if.addr, 8'h00);
        check_eq("rst_h_ack", h_if.ack, 1'b0);
        check_eq("rst_err", err, 1'b0);
        Rst = 1'b0;

        // Host-only write, target acks 3 cycles after m_cs.
        h_if.cs = 1'b1; h_if.we = 1'b1; h_if.addr = 8'h10; h_if.wdata = 32'h1234_5678;
        cycle();
        cycle();
        check_eq("t1_grant_lat", obs_m_cs, 1'b1);
        cycle(); cycle();
        m_if.ack = 1'b1;
        cycle();
        check_eq("t1_h_ack", obs_h_ack, 1'b1);
        check_eq("t1_c_ack", obs_c_ack, 1'b0);
        quiet();
        cycle();

        // Core-only read.
        c_if.cs = 1'b1; c_if.addr = 8'h04;
        cycle();
        m_if.ack = 1'b1; m_if.rdata = 32'hCAFE_0001;
        cycle();
        check_eq("t2_c_rdata", obs_c_rdata, 32'hCAFE_0001);
        check_eq("t2_h_rdata", obs_h_rdata, 32'h0);
        quiet();
        cycle();

        // Round-robin from reset: H, C, H, C with an IDLE cycle between.
        Rst = 1'b1; cycle(); Rst = 1'b0;
        h_if.cs = 1'b1; c_if.cs = 1'b1; m_if.ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i % 2 == 1) seq_h[i / 2] = obs_h_ack ? 1 : (obs_c_ack ? 2 : 0);
            else check_eq("rr_idle_gap", obs_h_ack | obs_c_ack, 1'b0);
        end
        for (int k = 0; k < 4; k++) check_eq("rr_order", seq_h[k], (k % 2 == 0) ? 1 : 2);

        // Host priority: host takes every conflict, core only when host is quiet.
        host_prio = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i % 2 == 1) check_eq("prio_host", obs_h_ack, 1'b1);
        end
        h_if.cs = 1'b0;
        cycle(); cycle();
        check_eq("prio_core_alone", obs_c_ack, 1'b1);
        quiet(); host_prio = 1'b0;
        cycle();

        // Requester abort leaves last untouched: core held it, so host wins next tie.
        h_if.cs = 1'b1;
        cycle(); cycle();
        h_if.cs = 1'b0;
        cycle();
        check_eq("abort_no_ack", obs_h_ack, 1'b0);
        h_if.cs = 1'b1; c_if.cs = 1'b1;
        cycle();
        m_if.ack = 1'b1;
        cycle();
        check_eq("abort_last_kept", obs_h_ack, 1'b1);
        quiet();
        cycle();

        // Reset in the middle of a grant.
        h_if.cs = 1'b1;
        cycle(); cycle();
        Rst = 1'b1;
        cycle();
        Rst = 1'b0;
        cycle();
        check_eq("rst_mid_grant", obs_m_cs, 1'b0);
        quiet();
        cycle(); cycle();

        if (WD_ON) begin
            h_if.cs = 1'b1;
            cycle();
            n = 0;
            for (int k = 0; k < 20; k++) begin
                cycle();
                n++;
                if (obs_h_ack) break;
            end
            check_eq("wd_cycles", n, TMO + 1);
            check_eq("wd_rdata", obs_h_rdata, 32'hDEAD_BEEF);
            check_eq("wd_err", obs_err, 1'b1);
            cycle();
            check_eq("wd_err_pulse", obs_err, 1'b0);
            check_eq("wd_back_idle", obs_m_cs, 1'b0);
            quiet();
            cycle();
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (h_if.cs) h_if.cs = ($urandom_range(15) != 0);
            else begin
                h_if.cs = 1'($urandom_range(1)); h_if.we = 1'($urandom_range(1));
                h_if.addr = 8'($urandom); h_if.wdata = $urandom;
            end
            if (c_if.cs) c_if.cs = ($urandom_range(15) != 0);
            else begin
                c_if.cs = 1'($urandom_range(1)); c_if.we = 1'($urandom_range(1));
                c_if.addr = 8'($urandom); c_if.wdata = $urandom;
            end
            m_if.ack = ($urandom_range(2) == 0);
            m_if.rdata = $urandom;
            if ($urandom_range(31) == 0) host_prio = ~host_prio;
            Rst = ($urandom_range(199) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the peripheral register bus (8-bit address, 32-bit data, `cs`/`we`/`ack` handshake). It lets the ASCII command decoder (host port) and the RISC core data port share one target bus. Arbitration is round-robin, with an optional host-priority override for debug sessions. Each grant is held for the whole transaction, and an optional watchdog terminates stalled transactions.

## Interface
Parameters:
- `ADDR_W`, 8, bus address width
- `DATA_W`, 32, bus data width
- `TIMEOUT_CYCLES`, 255, watchdog limit in cycles from `m_cs` rise (used only when the watchdog is compiled in)

Ports:
- `clk`  in  1  single clock, all logic on its rising edge
- `Rst`  in  1  reset, synchronous, active-high
- `host_prio`  in  1  1 = host wins every conflict (round-robin suspended)
- `h_cs`, `h_we`  in  1  host request and write enable
- `h_addr`  in  ADDR_W  host address
- `h_wdata`  in  DATA_W  host write data
- `h_ack`  out  1  host transaction done
- `h_rdata`  out  DATA_W  host read data
- `c_cs`, `c_we`, `c_addr`, `c_wdata`, `c_ack`, `c_rdata`  same as the host set, for the core port
- `m_cs`, `m_we`  out  1  target bus select and write enable
- `m_addr`  out  ADDR_W  target address
- `m_wdata`  out  DATA_W  target write data
- `m_ack`  in  1  target completion
- `m_rdata`  in  DATA_W  target read data, valid with `m_ack`
- `err`  out  1  one-cycle pulse when a transaction is aborted

## Operation
- FSM states: IDLE, GNT_H, GNT_C.
- IDLE: sample `h_cs` and `c_cs`.
  - One requester active -> grant it.
  - Both active -> host if `host_prio` = 1; otherwise the port not named by `last` (a 1-bit register, 0 = host, 1 = core).
  - None active -> stay in IDLE.
- GNT_x: `m_cs`/`m_we`/`m_addr`/`m_wdata` = the granted port's signals, combinationally. `m_cs` = `x_cs` & grant.
- GNT_x, completion: `x_ack` = `m_ack` (combinational) and `x_rdata` = `m_rdata`. The non-granted port sees ack = 0 and rdata = 0.
- GNT_x -> IDLE on `m_ack`; `last` <= x on the same edge.
- GNT_x -> IDLE if `x_cs` drops before `m_ack` (requester abort). No ack is given and `last` is unchanged.
- `m_ack` while in IDLE is ignored; no ack reaches either port.
- Outside a grant, all `m_*` outputs are 0.

## Timing
- Arbitration latency: 1 cycle. Request seen in IDLE at edge N -> `m_cs` = 1 from N+1.
- Ack is passed through in the same cycle it arrives.
- There is always at least one IDLE cycle between transactions. Back-to-back requesters alternate under round-robin.
- Simultaneous requests with `host_prio` = 0 and `last` = 1 -> host wins. The next conflict goes to the core.
- `host_prio` is sampled only in IDLE. Changing it mid-grant does not preempt the current transaction.
- Reset values:
  - state = IDLE, `last` = 1 (host wins the first tie)
  - `m_cs`, `m_we`, `h_ack`, `c_ack`, `err` = 0
  - `m_addr`, `m_wdata`, `h_rdata`, `c_rdata` = 0
  - watchdog counter = 0
- Asserting `Rst` mid-grant returns to IDLE on the next edge. No ack is issued and the aborted transaction is not retried.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to GNT_x and increments each cycle in GNT_x without `m_ack`.
  - When the counter equals `TIMEOUT_CYCLES`, the FSM returns to IDLE on that edge.
  - In that cycle the arbiter drives `x_ack` = 1 and `x_rdata` = `32'hDEAD_BEEF`, and pulses `err` = 1 for one cycle. `last` updates as for a normal completion.
  - `m_ack` in the same cycle as the limit wins: normal completion, no `err`.
- Macro undefined: there is no counter, the FSM waits indefinitely for `m_ack`, and `err` is tied to 0.

## Structure
- Shared `bus_pkg` holds:
  - `BUS_ADDR_W`, `BUS_DATA_W`
  - `arb_state_t` enum {IDLE, GNT_H, GNT_C}
  - `BUS_ERR_RDATA` = `32'hDEAD_BEEF`
- Sub-module `bus_watchdog` (counter plus expiry compare) is instantiated only under `BUS_ARB_TIMEOUT_EN`.
- The grant-select and mux logic stays in `bus_arbiter`.

## Test plan
- Host-only write (`h_cs` = 1, `h_we` = 1, `h_addr` = 8'h10, `h_wdata` = 32'h1234_5678; `m_ack` 3 cycles after `m_cs`):
  - `m_cs` = 1 one cycle after request, `m_addr` = 8'h10, `m_wdata` = 32'h1234_5678.
  - `h_ack` = 1 in the `m_ack` cycle; `c_ack` stays 0.
- Core-only read (`c_addr` = 8'h04; `m_rdata` = 32'hCAFE_0001 with `m_ack`):
  - `c_rdata` = 32'hCAFE_0001 and `c_ack` = 1; `h_rdata` = 0.
- Both requesting continuously, `host_prio` = 0, immediate `m_ack`:
  - Grants go H, C, H, C after reset.
  - Each grant is separated by one IDLE cycle.
- Both requesting, `host_prio` = 1:
  - Host granted on every conflict.
  - Core granted only when `h_cs` = 0.
- Requester abort and mid-grant reset:
  - `h_cs` drops before `m_ack` -> IDLE next cycle, no `h_ack`, `last` unchanged.
  - `Rst` mid-grant -> all outputs 0 next cycle.
- Watchdog (`BUS_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4, `m_ack` never asserted):
  - After 4 cycles: `h_ack` = 1, `h_rdata` = 32'hDEAD_BEEF, `err` pulses 1 cycle, FSM returns to IDLE.
